fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Initiator side of the instruction ROM interface.
- Generates byte addresses, drives the ROM's address/enable, and captures the returned 32-bit words (little-endian, byte-addressed storage).
- Buffers captured words in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush, and flags illegal fetch addresses.

Parameters:
- RESET_PC, 0, PC loaded on reset; must be word-aligned.
- MAX_ADDR, 1020, highest legal fetch address (last full word in the 1024-byte ROM).
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching.
- redirect_valid  in  1  load redirect_pc and flush all buffered/in-flight words.
- redirect_pc  in  32  new fetch address.
- rom_addr  out  32  byte address to ROM (registered).
- rom_enable  out  1  read strobe to ROM (registered).
- rom_data  in  32  word returned by ROM for the address presented this cycle.
- instr_valid  out  1  instr_data/instr_pc hold a valid word.
- instr_data  out  32  fetched instruction word.
- instr_pc  out  32  byte address of instr_data.
- instr_ready  in  1  decode accepts the word this cycle.
- fault  out  1  sticky; illegal fetch address reached.
- busy  out  1  high in RUN while requests are in flight or the FIFO is non-empty.

Behaviour:
- Reset (async, active-high) values:
  - state=IDLE, pc=RESET_PC.
  - rom_addr=0, rom_enable=0.
  - FIFO empty, instr_valid=0, instr_data=0, instr_pc=0.
  - fault=0, busy=0, in-flight flag cleared.
  - Reset mid-operation discards everything; no partial word is ever presented.
- ROM timing: rom_addr and rom_enable are registered. The ROM drives rom_data combinationally during a cycle with rom_enable=1. The fetch unit captures {rom_data, rom_addr} into the FIFO at the next rising edge.
  - Latency: word presented on instr_* one cycle after its rom_enable cycle.
- FSM states:
  - IDLE: no fetch. start → RUN. redirect_valid in IDLE loads pc; with simultaneous start, the redirect_pc value is used.
  - RUN: issue one request per cycle while the issue condition holds.
  - FAULT: no issue; FIFO continues to drain; exit only by reset.
- Issue condition (evaluated each cycle in RUN): !redirect_valid, pc word-aligned, pc ≤ MAX_ADDR, and fifo_count + inflight − pop < FIFO_DEPTH. The FIFO can never overflow.
  - On issue: rom_addr←pc, rom_enable←1, pc←pc+4.
  - Otherwise rom_enable←0; rom_addr holds its value.
- Sequential overrun: when pc > MAX_ADDR, or pc is misaligned, in RUN → state←FAULT, fault←1.
  - Example: after issuing 1020, pc=1024 → FAULT.
  - pc arithmetic is 32-bit and wraps, but wrap is unreachable because the 1024 check precedes it.
- Handshake:
  - Pop when instr_valid && instr_ready.
  - instr_* hold stable while instr_valid && !instr_ready.
  - instr_valid = FIFO non-empty.
  - Push and pop in the same cycle are both honoured.
- Redirect (any cycle in RUN or IDLE): FIFO flushed, in-flight capture suppressed, rom_enable←0, pc←redirect_pc.
  - Redirect overrides a simultaneous pop; that word is discarded, not consumed.
  - First new request issues the following cycle if redirect_pc is legal.
  - Illegal redirect_pc in RUN → FAULT on the next cycle.
  - Redirect in FAULT is ignored.
- busy = (state==RUN) && (inflight || fifo non-empty || issue possible).

Decomposition:
- Shared package (cpu_pkg): ROM_BYTES=1024, MAX_ADDR constant, WORD_BYTES=4, fetch state enum {IDLE, RUN, FAULT}, and a fetch-entry struct {data[31:0], pc[31:0]}.
- One sub-module: fetch_fifo. Synchronous FIFO of FIFO_DEPTH entries with count output and flush input; the FSM and PC logic stay in fetch_unit.

Test Plan:
- Streaming fetch: ROM byte i = i for i<16, start pulse, instr_ready=1 → instr_valid first high 2 cycles after start. Words 0x03020100@0, 0x07060504@4, 0x0B0A0908@8, 0x0F0E0D0C@12, then 0 thereafter, one per cycle.
- Backpressure: instr_ready=0 for 6 cycles after start → exactly FIFO_DEPTH words buffered, rom_enable low, instr_data stable at 0x03020100. Release → words 0,4 then 8 in order, none lost or duplicated.
- Redirect mid-stream: redirect_pc=8 with instr_valid && instr_ready high in the same cycle → next accepted word is 0x0B0A0908 with instr_pc=8, no stale word from the old stream.
- End of ROM: redirect_pc=1016 → words at 1016 and 1020 delivered, then fault=1; rom_addr never exceeds 1020; FIFO drains normally.
- Illegal redirect: redirect_pc=1022 → no rom_enable, fault=1 next cycle, instr_valid=0.
- Async reset mid-stream with 2 words buffered → all outputs at reset values immediately; after release and start, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch path.
// Contents:
//   ROM_BYTES, WORD_BYTES, MAX_ADDR : instruction ROM geometry
//   fetch_state_t                   : fetch FSM states {IDLE, RUN, FAULT}
//   fetch_entry_t                   : one buffered word {data, pc}
//   addr_legal()                    : word-aligned and within the ROM
package cpu_pkg;

    localparam logic [31:0] ROM_BYTES  = 32'd1024;
    localparam logic [31:0] WORD_BYTES = 32'd4;
    // Last address at which a full word still fits in the ROM.
    localparam logic [31:0] MAX_ADDR   = ROM_BYTES - WORD_BYTES;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] max_addr);
        return (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the ROM capture stage and decode.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   flush       : drop every entry; wins over push and pop in the same cycle
//   push        : write push_entry at the tail
//   push_entry  : {data, pc} to store
//   pop         : retire the head entry
//   head        : entry at the head (meaningful only when count != 0)
//   count       : number of stored entries, 0..DEPTH
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    // Guards make the buffer safe even if the caller misbehaves.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != DEPTH_C) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head  = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: initiator side of the instruction ROM interface.
// Issues one word request per cycle, captures the ROM reply on the following
// edge into a small buffer and hands words to decode over valid/ready.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   start                    : pulse, leave IDLE and begin fetching
//   redirect_valid/_pc       : load a new pc and flush buffered/in-flight words
//   rom_addr, rom_enable     : registered ROM request
//   rom_data                 : ROM reply for the request presented this cycle
//   instr_valid/_data/_pc    : word offered to decode
//   instr_ready              : decode accepts the offered word
//   fault                    : sticky, illegal fetch address reached
//   busy                     : RUN with work in flight, buffered or issuable
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] MAX_ADDR   = cpu_pkg::MAX_ADDR,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] rom_addr,
    output logic        rom_enable,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault,
    output logic        busy
);

    import cpu_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rom_addr_q, rom_addr_d;
    logic         rom_enable_q, rom_enable_d;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  capture;
    logic          flush;
    logic          pop;
    logic          pc_legal;
    logic [CW:0]   occupancy;
    logic          room;
    logic          issue;

    // A request issued last cycle is in flight exactly when rom_enable is high,
    // so the registered strobe doubles as the in-flight flag.
    assign flush    = redirect_valid && (state_q != FAULT);
    assign pop      = instr_valid && instr_ready && !flush;
    assign pc_legal = addr_legal(pc_q, MAX_ADDR);

    // Slots committed after this edge: stored + arriving - leaving.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rom_enable_q} - {{CW{1'b0}}, pop};
    assign room      = occupancy < (CW + 1)'(FIFO_DEPTH);
    assign issue     = (state_q == RUN) && !redirect_valid && pc_legal && room;

    assign capture = '{data: rom_data, pc: rom_addr_q};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (rom_enable_q),
        .push_entry (capture),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rom_addr_d   = rom_addr_q;
        rom_enable_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (!pc_legal) begin
                    state_d = FAULT;
                end else if (issue) begin
                    rom_addr_d   = pc_q;
                    rom_enable_d = 1'b1;
                    pc_d         = pc_q + WORD_BYTES;
                end
            end
            FAULT: begin
                // Terminal until reset; buffered words still drain.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            rom_addr_q   <= '0;
            rom_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rom_addr_q   <= rom_addr_d;
            rom_enable_q <= rom_enable_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign rom_enable  = rom_enable_q;
    assign instr_valid = (fifo_count != '0);
    // Zero when empty so stale buffer contents are never visible.
    assign instr_data  = instr_valid ? fifo_head.data : '0;
    assign instr_pc    = instr_valid ? fifo_head.pc : '0;
    assign fault       = (state_q == FAULT);
    assign busy        = (state_q == RUN) && (rom_enable_q || instr_valid || issue);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic        rom_enable;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fault;
    logic        busy;

    int checks;
    int errors;

    logic [7:0] mem [0:1023];
    logic [9:0] ra;

    fetch_unit #(
        .RESET_PC   (32'd0),
        .MAX_ADDR   (32'd1020),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_addr       (rom_addr),
        .rom_enable     (rom_enable),
        .rom_data       (rom_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .fault          (fault),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian combinational ROM model.
    always_comb begin
        ra       = rom_addr[9:0];
        rom_data = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        instr_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        for (int i = 0; i < 8; i++) mem[1016 + i] = 8'hA0 + 8'(i);

        // Reset state
        do_reset();
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_en", {31'd0, rom_enable}, 32'd0);
        check("rst_addr", rom_addr, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Streaming fetch
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("st_valid0", {31'd0, instr_valid}, 32'd0);
        check("st_busy", {31'd0, busy}, 32'd1);
        step();
        check("st_valid1", {31'd0, instr_valid}, 32'd0);
        check("st_en", {31'd0, rom_enable}, 32'd1);
        check("st_addr", rom_addr, 32'd0);
        step();
        check("st_v0", {31'd0, instr_valid}, 32'd1);
        check("st_d0", instr_data, 32'h03020100);
        check("st_p0", instr_pc, 32'd0);
        step();
        check("st_d4", instr_data, 32'h07060504);
        check("st_p4", instr_pc, 32'd4);
        step();
        check("st_d8", instr_data, 32'h0B0A0908);
        check("st_p8", instr_pc, 32'd8);
        step();
        check("st_d12", instr_data, 32'h0F0E0D0C);
        check("st_p12", instr_pc, 32'd12);
        step();
        check("st_v16", {31'd0, instr_valid}, 32'd1);
        check("st_d16", instr_data, 32'h00000000);
        check("st_p16", instr_pc, 32'd16);

        // Backpressure
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("bp_valid", {31'd0, instr_valid}, 32'd1);
        check("bp_data", instr_data, 32'h03020100);
        check("bp_pc", instr_pc, 32'd0);
        check("bp_en", {31'd0, rom_enable}, 32'd0);
        check("bp_busy", {31'd0, busy}, 32'd1);
        instr_ready = 1'b1;
        step();
        check("bp_d4", instr_data, 32'h07060504);
        check("bp_p4", instr_pc, 32'd4);
        check("bp_en8", {31'd0, rom_enable}, 32'd1);
        check("bp_addr8", rom_addr, 32'd8);
        step();
        check("bp_d8", instr_data, 32'h0B0A0908);
        check("bp_p8", instr_pc, 32'd8);

        // Redirect mid-stream with a simultaneous accept
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("rd_head", instr_data, 32'h03020100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd8;
        step();
        redirect_valid = 1'b0;
        check("rd_flush", {31'd0, instr_valid}, 32'd0);
        check("rd_en0", {31'd0, rom_enable}, 32'd0);
        step();
        check("rd_valid", {31'd0, instr_valid}, 32'd0);
        check("rd_addr", rom_addr, 32'd8);
        step();
        check("rd_v8", {31'd0, instr_valid}, 32'd1);
        check("rd_d8", instr_data, 32'h0B0A0908);
        check("rd_p8", instr_pc, 32'd8);

        // End of ROM, redirect together with start
        do_reset();
        instr_ready    = 1'b1;
        start          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1016;
        step();
        start          = 1'b0;
        redirect_valid = 1'b0;
        step();
        check("eor_addr0", rom_addr, 32'd1016);
        step();
        check("eor_d0", instr_data, 32'hA3A2A1A0);
        check("eor_p0", instr_pc, 32'd1016);
        check("eor_addr1", rom_addr, 32'd1020);
        step();
        check("eor_d1", instr_data, 32'hA7A6A5A4);
        check("eor_p1", instr_pc, 32'd1020);
        check("eor_fault", {31'd0, fault}, 32'd1);
        check("eor_en", {31'd0, rom_enable}, 32'd0);
        check("eor_addr2", rom_addr, 32'd1020);
        step();
        check("eor_drain", {31'd0, instr_valid}, 32'd0);
        check("eor_busy", {31'd0, busy}, 32'd0);
        // Redirect in FAULT has no effect
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        step();
        redirect_valid = 1'b0;
        step();
        check("flt_en", {31'd0, rom_enable}, 32'd0);
        check("flt_fault", {31'd0, fault}, 32'd1);
        check("flt_valid", {31'd0, instr_valid}, 32'd0);

        // Illegal (misaligned) redirect
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1022;
        step();
        redirect_valid = 1'b0;
        check("ill_en0", {31'd0, rom_enable}, 32'd0);
        check("ill_fault0", {31'd0, fault}, 32'd0);
        step();
        check("ill_fault", {31'd0, fault}, 32'd1);
        check("ill_en1", {31'd0, rom_enable}, 32'd0);
        check("ill_valid", {31'd0, instr_valid}, 32'd0);

        // Asynchronous reset with two words buffered
        do_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("ar_pre_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b1;
        #1;
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_data", instr_data, 32'd0);
        check("ar_pc", instr_pc, 32'd0);
        check("ar_en", {31'd0, rom_enable}, 32'd0);
        check("ar_addr", rom_addr, 32'd0);
        check("ar_fault", {31'd0, fault}, 32'd0);
        check("ar_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b0;
        instr_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("ar_rs_d", instr_data, 32'h03020100);
        check("ar_rs_p", instr_pc, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
